mem_port_arbiter: RTL and testbench

- Shares the single unified word memory between two requesters: port 0 = CPU datapath (fetch/load/store), port 1 = loader/debug master.
- Sits between the requesters and the memory block. It serialises accesses, holds address and strobes stable for a programmable latency, and returns registered read data with a one-cycle ack.
- Gives the multi-cycle CPU a stall-capable memory interface so memory can be preloaded or inspected while the CPU runs.

---
 rtl/mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one word-addressed memory between two requesters: port 0 (CPU
//   datapath) and port 1 (loader/debug master). Accesses are serialised
//   through an IDLE -> ACCESS -> RESP sequence. Address, data and strobes are
//   held for MEM_LAT cycles. Completion is a registered one-cycle ack that
//   carries read data and a misalignment error flag.
//
// Parameters
//   AW       address width (byte address, bits [1:0] must be zero)
//   DW       data width
//   MEM_LAT  cycles the memory needs with address/strobe held (>= 1)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mX_req/we/lock/addr/wdata  request from port X (held until mX_ack)
//   mX_ack/err/rdata           registered completion for port X
//   mem_addr/mem_wdata         registered memory address / write data
//   mem_rd/mem_wr              strobes decoded from state, count and latched we
//   mem_rdata                  memory read data, sampled on the last cycle
//   busy                       high whenever the arbiter is not IDLE
//   owner                      port currently or most recently granted
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] m1_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy,
    output logic          owner
);

    localparam int            CW        = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_START = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Latched request direction; the address and write data are held
    // directly in the mem_addr / mem_wdata output registers.
    logic          lat_we;
    // Set when the last completed access belonged to a port asserting lock;
    // that port is always 'owner' because owner tracks the last grant.
    logic          lock_hold;

    logic          any_req;
    logic          grant_port;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          misaligned;
    logic          enter_resp;
    logic          resp_port;
    logic          resp_err;
    logic          capture_rd;

    // ------------------------------------------------------------------
    // Grant selection (only consumed in IDLE)
    // ------------------------------------------------------------------
    assign any_req = m0_req | m1_req;

    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        grant_port = 1'b0;
        if (lock_hold && (owner ? m1_req : m0_req)) begin
            grant_port = owner;
        end else if (m0_req && m1_req) begin
            // Round-robin: the port that did not win last time goes first.
            grant_port = ~owner;
        end else begin
            grant_port = m1_req;
        end
    end

    assign sel_we     = grant_port ? m1_we    : m0_we;
    assign sel_addr   = grant_port ? m1_addr  : m0_addr;
    assign sel_wdata  = grant_port ? m1_wdata : m0_wdata;
    assign misaligned = (sel_addr[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (misaligned) begin
                        state_next = RESP;
                    end else begin
                        state_next = ACCESS;
                        cnt_next   = CNT_START;
                    end
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory strobes: combinational so that an asynchronous reset drops them
    // at once. The write pulses only on the final held cycle.
    // ------------------------------------------------------------------
    assign mem_rd = (state == ACCESS) && !lat_we;
    assign mem_wr = (state == ACCESS) && lat_we && (cnt == '0);

    assign enter_resp = (state != RESP) && (state_next == RESP);
    // Entering RESP straight from IDLE happens only for a misaligned
    // request, so that path alone carries the error flag.
    assign resp_port  = (state == IDLE) ? grant_port : owner;
    assign resp_err   = (state == IDLE);
    assign capture_rd = (state == ACCESS) && (cnt == '0) && !lat_we;

    // ------------------------------------------------------------------
    // Control state and latched request
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lock_hold <= 1'b0;
            owner     <= 1'b1;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_next;
            cnt   <= cnt_next;
            busy  <= (state_next != IDLE);

            if (state == IDLE && any_req) begin
                owner  <= grant_port;
                lat_we <= sel_we;
                // A misaligned request never reaches the memory, so the bus
                // keeps its previous value.
                if (!misaligned) begin
                    mem_addr  <= sel_addr;
                    mem_wdata <= sel_wdata;
                end
            end

            if (state == RESP) begin
                lock_hold <= owner ? m1_lock : m0_lock;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-port completion registers. The non-owner's registers never change.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            // NOTE: the read-data holding registers are reset because they
            // are observable outputs with a defined post-reset value.
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            m0_ack <= enter_resp && !resp_port;
            m0_err <= enter_resp && !resp_port && resp_err;
            m1_ack <= enter_resp && resp_port;
            m1_err <= enter_resp && resp_port && resp_err;

            if (capture_rd && !owner) begin
                m0_rdata <= mem_rdata;
            end
            if (capture_rd && owner) begin
                m1_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Three arbiter instances (MEM_LAT = 1, 3, 4), each with its own word
//   memory model. Directed vectors and hand-written multi-cycle sequences use
//   fixed expectations. A random phase compares every output, every cycle,
//   against a transaction-timing reference model.
module tb_mem_port_arbiter;

    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [ND];
    logic        req       [ND][2];
    logic        we        [ND][2];
    logic        lock      [ND][2];
    logic [31:0] addr      [ND][2];
    logic [31:0] wdata     [ND][2];
    logic        ack       [ND][2];
    logic        err       [ND][2];
    logic [31:0] rdata     [ND][2];
    logic [31:0] mem_addr  [ND];
    logic [31:0] mem_wdata [ND];
    logic [31:0] mem_rdata [ND];
    logic        mem_rd    [ND];
    logic        mem_wr    [ND];
    logic        busy      [ND];
    logic        owner     [ND];

    logic [31:0] mem    [ND][256];
    bit          wvalid [ND][256];

    int n_checks = 0;
    int n_errors = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    // Contents of a word that has never been written.
    function automatic logic [31:0] init_word(input logic [7:0] idx);
        return (idx == 8'd4) ? 32'hDEADBEEF : {8'h5A, idx, ~idx, 8'hC3};
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        mem_port_arbiter #(
            .AW     (32),
            .DW     (32),
            .MEM_LAT((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n[g]),
            .m0_req   (req[g][0]),
            .m0_we    (we[g][0]),
            .m0_lock  (lock[g][0]),
            .m0_addr  (addr[g][0]),
            .m0_wdata (wdata[g][0]),
            .m0_ack   (ack[g][0]),
            .m0_err   (err[g][0]),
            .m0_rdata (rdata[g][0]),
            .m1_req   (req[g][1]),
            .m1_we    (we[g][1]),
            .m1_lock  (lock[g][1]),
            .m1_addr  (addr[g][1]),
            .m1_wdata (wdata[g][1]),
            .m1_ack   (ack[g][1]),
            .m1_err   (err[g][1]),
            .m1_rdata (rdata[g][1]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rd   (mem_rd[g]),
            .mem_wr   (mem_wr[g]),
            .mem_rdata(mem_rdata[g]),
            .busy     (busy[g]),
            .owner    (owner[g])
        );
    end

    always_comb begin
        for (int d = 0; d < ND; d++) begin
            mem_rdata[d] = wvalid[d][mem_addr[d][9:2]] ? mem[d][mem_addr[d][9:2]]
                                                       : init_word(mem_addr[d][9:2]);
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (mem_wr[d]) begin
                mem[d][mem_addr[d][9:2]]    <= mem_wdata[d];
                wvalid[d][mem_addr[d][9:2]] <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs(input int d);
        for (int p = 0; p < 2; p++) begin
            req[d][p]   = 1'b0;
            we[d][p]    = 1'b0;
            lock[d][p]  = 1'b0;
            addr[d][p]  = '0;
            wdata[d][p] = '0;
        end
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        rst_n[d] = 1'b0;
        clear_inputs(d);
        repeat (2) @(negedge clk);
        rst_n[d] = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Directed single-port vectors
    // ------------------------------------------------------------------
    typedef struct {
        int          d;
        int          port;
        bit          is_wr;
        logic [31:0] a;
        logic [31:0] wd;
        bit          exp_err;
        logic [31:0] exp_rdata;   // requester's rdata after the ack
        int          exp_lat;     // cycles from request to ack
        int          exp_rd;      // cycles with mem_rd high
        int          exp_wr_at;   // cycle of the mem_wr pulse, -1 for none
    } vec_t;

    task automatic single_access(input vec_t v, input string tag);
        int d         = v.d;
        int p         = v.port;
        int lat_seen  = -1;
        int rd_n      = 0;
        int wr_n      = 0;
        int wr_at     = -1;
        int other_ack = 0;
        @(negedge clk);
        req[d][p]   = 1'b1;
        we[d][p]    = v.is_wr;
        lock[d][p]  = 1'b0;
        addr[d][p]  = v.a;
        wdata[d][p] = v.wd;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (mem_rd[d]) rd_n++;
            if (mem_wr[d]) begin
                wr_n++;
                wr_at = n;
            end
            if (ack[d][1-p]) other_ack++;
            if (ack[d][p]) begin
                lat_seen = n;
                break;
            end
        end
        check({tag, " latency"}, lat_seen, v.exp_lat);
        check({tag, " err"}, err[d][p], v.exp_err);
        check({tag, " rdata"}, rdata[d][p], v.exp_rdata);
        check({tag, " mem_rd cycles"}, rd_n, v.exp_rd);
        check({tag, " mem_wr pulses"}, wr_n, (v.exp_wr_at >= 0) ? 1 : 0);
        check({tag, " mem_wr cycle"}, wr_at, v.exp_wr_at);
        check({tag, " other ack"}, other_ack, 0);
        req[d][p] = 1'b0;
    endtask

    // Both ports request continuously; grant i must go to exp_order[i].
    // With lock_mode, port 1 asserts lock through its first three completions.
    task automatic run_both(input int d, input int n, input bit lock_mode,
                            input logic [7:0] exp_order, input string tag);
        int got     = 0;
        int p1_acks = 0;
        int both    = 0;
        int p;
        @(negedge clk);
        for (int q = 0; q < 2; q++) begin
            req[d][q]  = 1'b1;
            we[d][q]   = 1'b0;
            addr[d][q] = 32'h100 + 32'(q * 4);
        end
        lock[d][0] = 1'b0;
        lock[d][1] = lock_mode;
        for (int c = 0; c < 40 && got < n; c++) begin
            @(negedge clk);
            if (ack[d][0] && ack[d][1]) begin
                both++;
            end else if (ack[d][0] || ack[d][1]) begin
                p = ack[d][1] ? 1 : 0;
                check($sformatf("%s grant %0d port", tag, got), p, exp_order[got]);
                got++;
                if (p == 1) p1_acks++;
                if (lock_mode) lock[d][1] = (p1_acks <= 2);
            end
        end
        check({tag, " simultaneous acks"}, both, 0);
        check({tag, " grants completed"}, got, n);
        clear_inputs(d);
    endtask

    // ------------------------------------------------------------------
    // Random traffic against a transaction-timing model: a grant in cycle g
    // acks in g+MEM_LAT+1 (g+1 if misaligned) and the next grant is
    // possible in the cycle after the ack.
    // ------------------------------------------------------------------
    task automatic run_random(input int d, input int ncyc);
        int          lat        = lat_of(d);
        int          g_cyc      = -100;
        int          ack_cyc    = -100;
        int          next_free  = 0;
        int          g_port     = 0;
        int          lock_port  = 0;
        int          w;
        bit          g_we       = 1'b0;
        bit          g_mis      = 1'b0;
        bit          m_owner    = 1'b1;
        bit          lock_valid = 1'b0;
        bit          in_acc;
        logic [31:0] g_addr     = '0;
        logic [31:0] g_wdata    = '0;
        logic [31:0] pend       = '0;
        logic [31:0] a;
        logic [7:0]  idx;
        logic [31:0] exp_rd [2];
        logic [31:0] rmem   [256];
        bit          rvalid [256];
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        do_reset(d);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (k == ack_cyc && !g_mis && !g_we) exp_rd[g_port] = pend;
            for (int p = 0; p < 2; p++) begin
                check($sformatf("rnd d%0d c%0d ack%0d", d, k, p), ack[d][p],
                      (k == ack_cyc && p == g_port));
                check($sformatf("rnd d%0d c%0d err%0d", d, k, p), err[d][p],
                      (k == ack_cyc && p == g_port && g_mis));
                check($sformatf("rnd d%0d c%0d rdata%0d", d, k, p), rdata[d][p], exp_rd[p]);
            end
            in_acc = !g_mis && (k > g_cyc) && (k <= g_cyc + lat);
            check($sformatf("rnd d%0d c%0d busy", d, k), busy[d], (k > g_cyc && k <= ack_cyc));
            check($sformatf("rnd d%0d c%0d mem_rd", d, k), mem_rd[d], in_acc && !g_we);
            check($sformatf("rnd d%0d c%0d mem_wr", d, k), mem_wr[d],
                  in_acc && g_we && (k == g_cyc + lat));
            check($sformatf("rnd d%0d c%0d owner", d, k), owner[d], m_owner);
            if (in_acc) check($sformatf("rnd d%0d c%0d mem_addr", d, k), mem_addr[d], g_addr);
            if (in_acc && g_we) check($sformatf("rnd d%0d c%0d mem_wdata", d, k), mem_wdata[d], g_wdata);

            // Requesters: finish on ack, then maybe start a new request at once.
            for (int p = 0; p < 2; p++) begin
                if (req[d][p] && k == ack_cyc && p == g_port) req[d][p] = 1'b0;
                if (!req[d][p] && $urandom_range(0, 2) != 0) begin
                    a = 32'h100 + 32'($urandom_range(0, 63)) * 4;
                    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
                    req[d][p]   = 1'b1;
                    we[d][p]    = 1'($urandom_range(0, 1));
                    lock[d][p]  = ($urandom_range(0, 2) == 0);
                    addr[d][p]  = a;
                    wdata[d][p] = $urandom;
                end
            end

            // Model reaction to this cycle's inputs.
            if (k == ack_cyc) begin
                lock_valid = lock[d][g_port];
                lock_port  = g_port;
            end
            if (k >= next_free && (req[d][0] || req[d][1])) begin
                if (lock_valid && req[d][lock_port]) w = lock_port;
                else if (req[d][0] && req[d][1]) w = m_owner ? 0 : 1;
                else w = req[d][1] ? 1 : 0;
                m_owner   = w[0];
                g_port    = w;
                g_cyc     = k;
                g_we      = we[d][w];
                g_addr    = addr[d][w];
                g_wdata   = wdata[d][w];
                g_mis     = (g_addr[1:0] != 2'b00);
                ack_cyc   = k + (g_mis ? 1 : lat + 1);
                next_free = ack_cyc + 1;
                if (!g_mis) begin
                    idx = g_addr[9:2];
                    if (g_we) begin
                        rmem[idx]   = g_wdata;
                        rvalid[idx] = 1'b1;
                    end else begin
                        pend = rvalid[idx] ? rmem[idx] : init_word(idx);
                    end
                end
            end
        end
        do_reset(d);
    endtask

    vec_t tbl [9];
    vec_t v;

    initial begin
        int acks_after;
        int wr_after;

        tbl[0] = '{0, 0, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 2, 1, -1};
        tbl[1] = '{1, 1, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0,        4, 0,  3};
        tbl[2] = '{1, 0, 1'b0, 32'h20, 32'h0,        1'b0, 32'h12345678, 4, 3, -1};
        tbl[3] = '{0, 0, 1'b0, 32'h13, 32'h0,        1'b1, 32'hDEADBEEF, 1, 0, -1};
        tbl[4] = '{2, 1, 1'b1, 32'h40, 32'hCAFEF00D, 1'b0, 32'h0,        5, 0,  4};
        tbl[5] = '{2, 1, 1'b0, 32'h40, 32'h0,        1'b0, 32'hCAFEF00D, 5, 4, -1};
        tbl[6] = '{0, 1, 1'b1, 32'h10, 32'hA5A5A5A5, 1'b0, 32'h0,        2, 0,  1};
        tbl[7] = '{0, 0, 1'b0, 32'h10, 32'h0,        1'b0, 32'hA5A5A5A5, 2, 1, -1};
        tbl[8] = '{2, 1, 1'b1, 32'h42, 32'h11111111, 1'b1, 32'hCAFEF00D, 1, 0, -1};

        for (int d = 0; d < ND; d++) begin
            rst_n[d] = 1'b0;
            clear_inputs(d);
        end

        // Reset values
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            for (int p = 0; p < 2; p++) begin
                check($sformatf("reset d%0d ack%0d", d, p), ack[d][p], 0);
                check($sformatf("reset d%0d err%0d", d, p), err[d][p], 0);
                check($sformatf("reset d%0d rdata%0d", d, p), rdata[d][p], 0);
            end
            check($sformatf("reset d%0d mem_rd", d), mem_rd[d], 0);
            check($sformatf("reset d%0d mem_wr", d), mem_wr[d], 0);
            check($sformatf("reset d%0d busy", d), busy[d], 0);
            check($sformatf("reset d%0d mem_addr", d), mem_addr[d], 0);
            check($sformatf("reset d%0d mem_wdata", d), mem_wdata[d], 0);
            check($sformatf("reset d%0d owner", d), owner[d], 1);
        end
        @(negedge clk);
        for (int d = 0; d < ND; d++) rst_n[d] = 1'b1;

        for (int i = 0; i < 9; i++) single_access(tbl[i], $sformatf("vec%0d", i));

        // Round-robin under continuous contention
        do_reset(0);
        run_both(0, 4, 1'b0, 8'b0000_1010, "rr");

        // Lock: a port 0 access first makes port 1 the tie winner
        v = '{0, 0, 1'b0, 32'h20, 32'h0, 1'b0, init_word(8'h08), 2, 1, -1};
        single_access(v, "pre-lock");
        run_both(0, 4, 1'b1, 8'b0000_0111, "lock");

        // Reset in the middle of a MEM_LAT=4 write
        do_reset(2);
        @(negedge clk);
        req[2][1]   = 1'b1;
        we[2][1]    = 1'b1;
        addr[2][1]  = 32'h60;
        wdata[2][1] = 32'h0BADF00D;
        repeat (2) @(negedge clk);
        check("abort busy before reset", busy[2], 1);
        #2;
        rst_n[2] = 1'b0;
        #1;
        check("abort busy", busy[2], 0);
        check("abort mem_rd", mem_rd[2], 0);
        check("abort mem_wr", mem_wr[2], 0);
        clear_inputs(2);
        repeat (2) @(negedge clk);
        rst_n[2]   = 1'b1;
        acks_after = 0;
        wr_after   = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack[2][0] || ack[2][1]) acks_after++;
            if (mem_wr[2]) wr_after++;
        end
        check("abort acks after release", acks_after, 0);
        check("abort writes after release", wr_after, 0);
        check("abort busy after release", busy[2], 0);
        run_both(2, 1, 1'b0, 8'b0000_0000, "post-reset tie");
        v = '{2, 1, 1'b0, 32'h60, 32'h0, 1'b0, init_word(8'h18), 5, 4, -1};
        single_access(v, "abort readback");

        for (int d = 0; d < ND; d++) run_random(d, 500);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
